// File: rtl/solar_pkg.sv
// solar_pkg: shared state encoding, irq bit positions and averaging constants for the panel scan sequencer
package solar_pkg;
  typedef enum logic [2:0] {IDLE, SETTLE, CONVERT, WAIT, STORE} state_t;
  localparam int IRQ_FAULT = 0;
  localparam int IRQ_TIMEOUT = 1;
  localparam int IRQ_SCAN = 2;
  localparam int AVG_SHIFT = 2;
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/solar_scan_seq_timer.sv
// solar_cyc_timer: loadable saturating down-counter; o_tc is high while the count is zero
module solar_cyc_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_tc
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge i_clk) begin
    if (i_rst) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end
  assign o_tc = (r_cnt == '0);
endmodule

// File: rtl/solar_scan_seq.sv
// solar_scan_seq: steps the panel mux, runs the ADC start/done handshake and flags under-voltage channels.
// Define SOLAR_AVG_EN to average four conversions per channel.
module solar_scan_seq
  import solar_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 12,
  parameter int SETTLE_CYC = 8,
  parameter int TIMEOUT_CYC = 255,
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              enable,
  input  logic [DATA_W-1:0] thresh,
  input  logic              fault_clr,
  input  logic              adc_done,
  input  logic [DATA_W-1:0] adc_data,
  output logic [CH_W-1:0]   ch_sel,
  output logic              adc_start,
  output logic              sample_valid,
  output logic [CH_W-1:0]   sample_ch,
  output logic [DATA_W-1:0] sample_data,
  output logic [NUM_CH-1:0] fault_mask,
  output logic [2:0]        irq
);
  localparam int TMR_W = $clog2(max_int(SETTLE_CYC, TIMEOUT_CYC) + 1);
  state_t r_state, w_next;
  logic [CH_W-1:0] r_ch, r_sample_ch;
  logic [DATA_W-1:0] r_sample_data, w_sample;
  logic [NUM_CH-1:0] r_fault, w_fault_set;
  logic r_irq_fault, r_irq_to;
  logic w_tc, w_tmr_load, w_timeout, w_adv, w_last, w_conv_last;
  logic [TMR_W-1:0] w_tmr_val;

  // One timer serves both the settle delay and the ADC response timeout.
  solar_cyc_timer #(.W(TMR_W)) u_tmr (
    .i_clk (wb_clk_i),
    .i_rst (wb_rst_i),
    .i_load(w_tmr_load),
    .i_val (w_tmr_val),
    .o_tc  (w_tc)
  );

`ifdef SOLAR_AVG_EN
  logic [AVG_SHIFT-1:0] r_cnt;
  logic [DATA_W+AVG_SHIFT-1:0] r_acc, w_sum;
  assign w_sum = r_acc + (DATA_W+AVG_SHIFT)'(adc_data);
  assign w_sample = w_sum[DATA_W+AVG_SHIFT-1:AVG_SHIFT];
  assign w_conv_last = &r_cnt;
  // Every channel passes through SETTLE, so that is where a fresh average starts.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || r_state == SETTLE) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (r_state == WAIT && adc_done) begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= w_sum;
    end
  end
`else
  assign w_sample = adc_data;
  assign w_conv_last = 1'b1;
`endif

  assign w_timeout = (r_state == WAIT) && w_tc && !adc_done;
  assign w_adv = (r_state == STORE) || w_timeout;
  assign w_last = (r_ch == CH_W'(NUM_CH - 1));
  assign w_tmr_load = (r_state == CONVERT) || (w_next == SETTLE && r_state != SETTLE);
  assign w_tmr_val = (r_state == CONVERT) ? TMR_W'(TIMEOUT_CYC - 1) : TMR_W'(SETTLE_CYC - 1);
  assign w_fault_set = (r_state == STORE && r_sample_data < thresh) ? (NUM_CH'(1) << r_ch) : '0;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_state <= IDLE;
    else r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = enable ? SETTLE : IDLE;
      SETTLE:  w_next = w_tc ? CONVERT : SETTLE;
      CONVERT: w_next = WAIT;
      WAIT:    w_next = adc_done ? (w_conv_last ? STORE : CONVERT) : (w_tc ? (enable ? SETTLE : IDLE) : WAIT);
      STORE:   w_next = enable ? SETTLE : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ch <= '0;
      r_sample_ch <= '0;
      r_sample_data <= '0;
      r_fault <= '0;
      r_irq_fault <= 1'b0;
      r_irq_to <= 1'b0;
    end else begin
      if (r_state == IDLE && enable) r_ch <= '0;
      else if (w_adv) r_ch <= w_last ? '0 : r_ch + 1'b1;
      if (r_state == WAIT && adc_done && w_conv_last) begin
        r_sample_ch <= r_ch;
        r_sample_data <= w_sample;
      end
      // A fault raised in the clearing cycle survives the clear.
      r_fault <= (fault_clr ? '0 : r_fault) | w_fault_set;
      r_irq_fault <= (fault_clr ? 1'b0 : r_irq_fault) | (|w_fault_set);
      if (w_timeout) r_irq_to <= 1'b1;
    end
  end

  assign ch_sel = r_ch;
  assign adc_start = (r_state == CONVERT);
  assign sample_valid = (r_state == STORE);
  assign sample_ch = r_sample_ch;
  assign sample_data = r_sample_data;
  assign fault_mask = r_fault;
  assign irq[IRQ_FAULT] = r_irq_fault;
  assign irq[IRQ_TIMEOUT] = r_irq_to;
  assign irq[IRQ_SCAN] = w_adv && w_last;
endmodule

// File: tb/tb_solar_scan_seq.sv
// tb_solar_scan_seq: randomized ADC model with a sample scoreboard plus directed timing, fault, timeout and reset checks
module tb_solar_scan_seq;
  logic wb_clk_i = 1'b0;
  logic wb_rst_i, enable, fault_clr, adc_done;
  logic [11:0] thresh, adc_data, sample_data;
  logic [1:0] ch_sel, sample_ch;
  logic adc_start, sample_valid;
  logic [3:0] fault_mask;
  logic [2:0] irq;

  solar_scan_seq dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .enable(enable), .thresh(thresh),
    .fault_clr(fault_clr), .adc_done(adc_done), .adc_data(adc_data), .ch_sel(ch_sel),
    .adc_start(adc_start), .sample_valid(sample_valid), .sample_ch(sample_ch),
    .sample_data(sample_data), .fault_mask(fault_mask), .irq(irq)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {logic [1:0] ch; logic [11:0] data;} exp_t;
  exp_t q[$];
  int cyc = 0;
  int checks = 0, errors = 0;
  bit directed = 1, mute = 0, exp_to = 0;
  int drop_ch = -1, late_at = -1;

  always @(posedge wb_clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge wb_clk_i);
      #1;
    end
  endtask

  task automatic wait_start(input int ch, output int c);
    c = -1;
    for (int i = 0; i < 2000; i++) begin
      if (adc_start && (ch < 0 || ch_sel == 2'(ch))) begin
        c = cyc;
        return;
      end
      step(1);
    end
    checks++;
    errors++;
    $display("FAIL wait_start: no adc_start for ch %0d within bound", ch);
  endtask

  task automatic wait_valid(input int ch, output int c);
    c = -1;
    for (int i = 0; i < 2000; i++) begin
      if (sample_valid && sample_ch == 2'(ch)) begin
        c = cyc;
        return;
      end
      step(1);
    end
    checks++;
    errors++;
    $display("FAIL wait_valid: no sample_valid for ch %0d within bound", ch);
  endtask

  // ADC model: answers each adc_start after a latency with data chosen by the test phase.
  initial begin
    int lat = 0, acc = 0, n = 0;
    logic [11:0] d;
    adc_done = 0;
    adc_data = 0;
    forever begin
      @(posedge wb_clk_i);
      #1;
      adc_done = 0;
      if (cyc == late_at) begin
        adc_done = 1;
        adc_data = 12'h5A5;
      end else if (adc_start && !wb_rst_i) begin
        if (mute || int'(ch_sel) == drop_ch) begin
          lat = 0;
          acc = 0;
          n = 0;
        end else lat = directed ? 3 : int'($urandom_range(1, 8));
      end else if (lat > 0) begin
        lat--;
        if (lat == 0) begin
          d = directed ? ((ch_sel == 2) ? 12'h3FF : 12'h400) : 12'($urandom);
          adc_done = 1;
          adc_data = d;
`ifdef SOLAR_AVG_EN
          acc += int'(d);
          n++;
          if (n == 4) begin
            q.push_back('{ch: ch_sel, data: 12'(acc / 4)});
            acc = 0;
            n = 0;
          end
`else
          q.push_back('{ch: ch_sel, data: d});
`endif
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every strobe and tracks the sticky fault state.
  initial begin
    logic [3:0] em = 0, setb;
    logic ei0 = 0;
    exp_t e;
    forever begin
      @(negedge wb_clk_i);
      chk("fault_mask", fault_mask, em);
      chk("irq_fault", irq[0], ei0);
      chk("irq_timeout", irq[1], exp_to);
      setb = 0;
      if (sample_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sample: ch %0d data %0h with empty scoreboard", sample_ch, sample_data);
        end else begin
          e = q.pop_front();
          chk("sample_ch", sample_ch, e.ch);
          chk("sample_data", sample_data, e.data);
          chk("irq_scan", irq[2], e.ch == 2'd3);
          if (e.data < thresh) setb[e.ch] = 1'b1;
        end
      end else chk("irq_scan_quiet", irq[2], 1'b0);
      if (wb_rst_i) begin
        em = 0;
        ei0 = 0;
      end else begin
        em = (fault_clr ? 4'b0 : em) | setb;
        ei0 = (fault_clr ? 1'b0 : ei0) | (|setb);
      end
    end
  end

  initial begin
    int e, s, s2, v, n_st;
    wb_rst_i = 1;
    enable = 0;
    fault_clr = 0;
    thresh = 12'h400;
    step(3);
    wb_rst_i = 0;
    step(1);
    chk("rst_ch_sel", ch_sel, 0);
    chk("rst_adc_start", adc_start, 0);
    chk("rst_sample_valid", sample_valid, 0);
    chk("rst_sample_ch", sample_ch, 0);
    chk("rst_sample_data", sample_data, 0);
    chk("rst_irq", irq, 0);
    // first scan timing from the enable cycle
    enable = 1;
    e = cyc;
    wait_start(-1, s);
    chk("start_latency", s - e, 9);
`ifndef SOLAR_AVG_EN
    wait_valid(0, v);
    chk("valid_latency", v - e, 13);
`endif
    wait_valid(3, v);
    wait_valid(2, v);
    fault_clr = 1;
    step(1);
    fault_clr = 0;
    step(2);
    chk("mask_clr_refault", fault_mask, 4'b0100);
    chk("irq0_clr_refault", irq[0], 1);
    wait_valid(3, v);
    fault_clr = 1;
    step(1);
    fault_clr = 0;
    step(1);
    chk("mask_cleared", fault_mask, 0);
    // drop enable during ch1 settle
    wait_valid(0, v);
    step(1);
    enable = 0;
    wait_valid(1, v);
    step(3);
    chk("idle_ch_sel", ch_sel, 2);
    n_st = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (adc_start) n_st++;
    end
    chk("idle_no_start", n_st, 0);
    enable = 1;
    e = cyc;
    wait_start(-1, s);
    chk("restart_latency", s - e, 9);
    chk("restart_ch", ch_sel, 0);
    // ADC silent on ch1
    drop_ch = 1;
    wait_start(1, s);
    step(255);
    chk("timeout_not_yet", irq[1], 0);
    step(1);
    exp_to = 1;
    chk("timeout_set", irq[1], 1);
    wait_start(2, s2);
    chk("after_timeout_ch2", s2 - s, 264);
    drop_ch = -1;
    step(1);
    // reset while waiting for the ADC, done arriving just after release
    mute = 1;
    wait_start(-1, s);
    step(2);
    wb_rst_i = 1;
    enable = 0;
    late_at = cyc + 2;
    step(1);
    wb_rst_i = 0;
    exp_to = 0;
    n_st = 0;
    for (int i = 0; i < 12; i++) begin
      if (adc_start || sample_valid) n_st++;
      step(1);
    end
    chk("rst_mid_no_activity", n_st, 0);
    chk("rst_mid_outputs", {ch_sel, sample_ch, sample_data, fault_mask, irq}, 0);
    // randomized scanning
    mute = 0;
    directed = 0;
    enable = 1;
    for (int i = 0; i < 4000; i++) begin
      fault_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 63) == 0) thresh = 12'($urandom);
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      step(1);
    end
    enable = 0;
    fault_clr = 0;
    step(80);
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
